// File: rtl/data_sram_responder_pkg.sv
// Shared types and helpers for the data SRAM responder slice.
package data_sram_responder_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned WE_W   = 4;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   function automatic logic [DATA_W-1:0] be_merge(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] wdata,
      input logic [WE_W-1:0]   we
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int unsigned i = 0; i < WE_W; i++) begin
         if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_responder_array.sv
// Single-port word array with byte-lane write enables and read-first registered output.
module sram_be_array
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic [WE_W-1:0]   we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] wr_word_d;

   always_comb begin
      rdata_d   = mem_q[addr];
      wr_word_d = be_merge(rdata_d, wdata, we);
   end

   // Storage carries no reset; the responder's INIT pass defines contents.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata_q     <= rdata_d;
         mem_q[addr] <= wr_word_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder_cnt.sv
// Generic saturating up-counter used for the responder statistics.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-style data responder: zero-fill INIT FSM, window decode, 1-cycle read data, stats.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sram_en,
   input  logic [WE_W-1:0]   sram_we,
   input  logic [31:0]       sram_addr,
   input  logic [DATA_W-1:0] sram_wdata,
   output logic [DATA_W-1:0] sram_rdata,
   output logic              init_done,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  oob_cnt
);

   localparam logic [31:0] BASE = BASE_ADDR;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              zero_q, zero_d;

   logic              in_range;
   logic              accept;
   logic [ADDR_W-1:0] idx;
   logic              arr_en;
   logic [WE_W-1:0]   arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;
   logic              rd_inc, wr_inc, oob_inc;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^sram_addr[1:0];
   assign idx      = sram_addr[ADDR_W+1:2];
   assign in_range = (sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
   assign accept   = (state_q == ST_READY) && sram_en;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      zero_d    = zero_q;
      arr_en    = 1'b0;
      arr_we    = '0;
      arr_addr  = idx;
      arr_wdata = sram_wdata;
      rd_inc    = 1'b0;
      wr_inc    = 1'b0;
      oob_inc   = 1'b0;
      case (state_q)
         ST_INIT: begin
            arr_en    = 1'b1;
            arr_we    = '1;
            arr_addr  = ptr_q;
            arr_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = ST_READY;
         end
         ST_READY: begin
            if (accept) begin
               // Out-of-range responses are zeroed by masking the held array output.
               zero_d  = !in_range;
               arr_en  = in_range;
               arr_we  = sram_we;
               rd_inc  = in_range && (sram_we == '0);
               wr_inc  = in_range && (sram_we != '0);
               oob_inc = !in_range;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         zero_q  <= zero_d;
      end
   end

   sram_be_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   assign sram_rdata = zero_q ? '0 : arr_rdata;
   assign init_done  = (state_q == ST_READY);

   sat_counter #(.W(CNT_W)) u_rd_cnt  (.clk(clk), .rst(reset), .inc(rd_inc),  .cnt(rd_cnt));
   sat_counter #(.W(CNT_W)) u_wr_cnt  (.clk(clk), .rst(reset), .inc(wr_inc),  .cnt(wr_cnt));
   sat_counter #(.W(CNT_W)) u_oob_cnt (.clk(clk), .rst(reset), .inc(oob_inc), .cnt(oob_cnt));

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder with a word-array reference model.
module tb_data_sram_responder;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 16;
   localparam logic [31:0] BASE   = 32'h1c00_0000;
   localparam int unsigned CNT_W  = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              sram_en = 1'b0;
   logic [3:0]        sram_we = '0;
   logic [31:0]       sram_addr = '0;
   logic [31:0]       sram_wdata = '0;
   logic [31:0]       sram_rdata;
   logic              init_done;
   logic [CNT_W-1:0]  rd_cnt, wr_cnt, oob_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rdata;
   int unsigned exp_rd, exp_wr, exp_oob;
   bit          ready_m;

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .init_done  (init_done),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt),
      .oob_cnt    (oob_cnt)
   );

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
      exp_rdata = 32'h0;
      exp_rd = 0; exp_wr = 0; exp_oob = 0;
      ready_m = 1'b0;
   endtask

   // Drive a request at the negedge, let one rising edge pass, update model, return at next negedge.
   task automatic do_req(input bit en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
      int unsigned w;
      logic [31:0] merged;
      sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd;
      @(posedge clk);
      if (ready_m && en) begin
         if ((addr >= BASE) && (addr < BASE + 4*DEPTH)) begin
            w = (addr - BASE) / 4;
            exp_rdata = mem_m[w];
            if (we != 4'h0) begin
               merged = mem_m[w];
               for (int l = 0; l < 4; l++)
                  if (we[l]) merged[8*l +: 8] = wd[8*l +: 8];
               mem_m[w] = merged;
               exp_wr++;
            end else begin
               exp_rd++;
            end
         end else begin
            exp_rdata = 32'h0;
            exp_oob++;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_init();
      for (int c = 1; c <= DEPTH; c++) begin
         do_req(1'b1, 4'h0, BASE + 32'h3c, 32'h0);
         n_tests++;
         if (init_done !== (c == DEPTH)) begin
            n_fail++;
            $display("FAIL init_done cycle %0d: got %b want %b", c, init_done, (c == DEPTH));
         end
      end
      ready_m = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      n_tests++;
      if (sram_rdata !== 32'h0 || init_done !== 1'b0 || rd_cnt !== 0 || wr_cnt !== 0 || oob_cnt !== 0) begin
         n_fail++;
         $display("FAIL reset_state: rdata=%h done=%b rd=%0d wr=%0d oob=%0d want all zero",
                  sram_rdata, init_done, rd_cnt, wr_cnt, oob_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      run_init();
      n_tests++;
      if (sram_rdata !== 32'h0 || rd_cnt !== 0) begin
         n_fail++;
         $display("FAIL init_ignored: rdata=%h rd=%0d want 0 0", sram_rdata, rd_cnt);
      end
      do_req(1'b1, 4'h0, BASE, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'h0 || rd_cnt !== 1) begin
         n_fail++;
         $display("FAIL first_read: rdata=%h rd=%0d want 0 1", sram_rdata, rd_cnt);
      end
   endtask

   task automatic test_write_read();
      do_req(1'b1, 4'hf, BASE + 8, 32'hdeadbeef);
      do_req(1'b1, 4'h0, BASE + 8, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'hdeadbeef || sram_rdata !== exp_rdata) begin
         n_fail++;
         $display("FAIL raw_read: got %h want %h", sram_rdata, 32'hdeadbeef);
      end
      n_tests++;
      if (wr_cnt !== exp_wr || rd_cnt !== exp_rd || wr_cnt !== 1) begin
         n_fail++;
         $display("FAIL raw_counts: wr=%0d rd=%0d want %0d %0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
      end
   endtask

   task automatic test_lane_merge();
      do_req(1'b1, 4'b0101, BASE + 8, 32'h11223344);
      n_tests++;
      if (sram_rdata !== 32'hdeadbeef) begin
         n_fail++;
         $display("FAIL read_first: got %h want %h", sram_rdata, 32'hdeadbeef);
      end
      do_req(1'b0, 4'h0, 32'h0, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'hdeadbeef) begin
         n_fail++;
         $display("FAIL idle_hold: got %h want %h", sram_rdata, 32'hdeadbeef);
      end
      do_req(1'b1, 4'h0, BASE + 8 + 3, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'hde22be44 || sram_rdata !== exp_rdata) begin
         n_fail++;
         $display("FAIL lane_merge: got %h want %h", sram_rdata, 32'hde22be44);
      end
   endtask

   task automatic test_oob();
      int unsigned oob0;
      oob0 = exp_oob;
      do_req(1'b1, 4'hf, BASE + 0, 32'ha5a5a5a5);
      do_req(1'b1, 4'hf, BASE + 60, 32'h5a5a5a5a);
      do_req(1'b1, 4'h0, BASE + 60, 32'h0);
      do_req(1'b1, 4'hf, BASE - 4, 32'hffffffff);
      n_tests++;
      if (sram_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL oob_low_rdata: got %h want 0", sram_rdata);
      end
      do_req(1'b1, 4'hf, BASE + 4*DEPTH, 32'hffffffff);
      n_tests++;
      if (sram_rdata !== 32'h0 || oob_cnt !== oob0 + 2) begin
         n_fail++;
         $display("FAIL oob_high: rdata=%h oob=%0d want 0 %0d", sram_rdata, oob_cnt, oob0 + 2);
      end
      do_req(1'b1, 4'h0, BASE, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'ha5a5a5a5) begin
         n_fail++;
         $display("FAIL oob_idx0: got %h want %h", sram_rdata, 32'ha5a5a5a5);
      end
      do_req(1'b1, 4'h0, BASE + 60, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'h5a5a5a5a) begin
         n_fail++;
         $display("FAIL oob_idx15: got %h want %h", sram_rdata, 32'h5a5a5a5a);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned wr0, rd0;
      logic [31:0] data [DEPTH];
      wr0 = exp_wr; rd0 = exp_rd;
      for (int i = 0; i < DEPTH; i++) begin
         data[i] = $urandom;
         do_req(1'b1, 4'hf, BASE + 4*i, data[i]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b1, 4'h0, BASE + 4*i, 32'h0);
         n_tests++;
         if (sram_rdata !== data[i]) begin
            n_fail++;
            $display("FAIL b2b_read idx %0d: got %h want %h", i, sram_rdata, data[i]);
         end
      end
      n_tests++;
      if (wr_cnt !== wr0 + 16 || rd_cnt !== rd0 + 16) begin
         n_fail++;
         $display("FAIL b2b_counts: wr=%0d rd=%0d want %0d %0d", wr_cnt, rd_cnt, wr0 + 16, rd0 + 16);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 7))
            0:       a = BASE + 4*DEPTH + 4*$urandom_range(0, 255);
            1:       a = BASE - 4 - 4*$urandom_range(0, 255);
            default: a = BASE + $urandom_range(0, 4*DEPTH - 1);
         endcase
         do_req($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, a, $urandom);
         n_tests++;
         if (sram_rdata !== exp_rdata || rd_cnt !== exp_rd || wr_cnt !== exp_wr || oob_cnt !== exp_oob) begin
            n_fail++;
            $display("FAIL random step %0d: rdata=%h rd=%0d wr=%0d oob=%0d want %h %0d %0d %0d",
                     n, sram_rdata, rd_cnt, wr_cnt, oob_cnt, exp_rdata, exp_rd, exp_wr, exp_oob);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_req(1'b1, 4'hf, BASE + 20, 32'hcafef00d);
      do_req(1'b1, 4'h0, BASE + 20, 32'h0);
      sram_en = 1'b1; sram_we = 4'h0; sram_addr = BASE + 20;
      #2 reset = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if (sram_rdata !== 32'h0 || init_done !== 1'b0 || rd_cnt !== 0 || wr_cnt !== 0 || oob_cnt !== 0) begin
         n_fail++;
         $display("FAIL async_reset: rdata=%h done=%b rd=%0d wr=%0d oob=%0d want all zero",
                  sram_rdata, init_done, rd_cnt, wr_cnt, oob_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      run_init();
      do_req(1'b1, 4'h0, BASE + 20, 32'h0);
      n_tests++;
      if (sram_rdata !== 32'h0 || rd_cnt !== 1) begin
         n_fail++;
         $display("FAIL rezero: rdata=%h rd=%0d want 0 1", sram_rdata, rd_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_lane_merge();
      test_oob();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the core's SRAM-style data interface (en / we[3:0] / addr / wdata -> rdata).
- The core drives requests from EX and samples rdata in MEM, one cycle later. This block owns the backing word array and returns read data with a fixed 1-cycle latency.
- Writes are byte-lane masked.
- After reset, an init state machine zero-fills the array. Statistics counters and an out-of-range detector support simulation and FPGA debug.

Parameters:
- ADDR_W, 12, word-address width; array depth = 2**ADDR_W words.
- BASE_ADDR, 32'h1c00_0000, byte address of word 0; must be aligned to 4*2**ADDR_W.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sram_en  in  1  request valid this cycle.
- sram_we  in  4  byte-lane write enables; 4'b0000 with sram_en high = read.
- sram_addr  in  32  byte address; bits [1:0] ignored.
- sram_wdata  in  32  write data, lane i = bits [8i+7:8i].
- sram_rdata  out  32  registered response data.
- init_done  out  1  high once zero-fill is complete; requests are serviced only while high.
- rd_cnt  out  CNT_W  accepted in-range reads.
- wr_cnt  out  CNT_W  accepted in-range writes (any we bit set).
- oob_cnt  out  CNT_W  accepted requests outside the window.

Behaviour:
- Reset (async assert, sync release):
  - state=INIT, fill pointer=0, sram_rdata=0, init_done=0, all counters=0.
  - Array contents are undefined until INIT completes.
- FSM INIT:
  - Each cycle, write 32'h0 to mem[ptr] and increment ptr.
  - When ptr==2**ADDR_W-1 is written, go to READY next edge; init_done=1 from that edge.
  - INIT lasts exactly 2**ADDR_W cycles.
  - Requests during INIT are ignored: no array write, no counter change, sram_rdata held at 0.
- FSM READY: terminal state; only reset leaves it. Reset mid-INIT or mid-READY restarts INIT from ptr=0.
- Window decode:
  - idx = sram_addr[ADDR_W+1:2].
  - In range iff sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- Accepted request = READY && sram_en.
- Read (we==0), in range: sram_rdata <= mem[idx] at the next edge; rd_cnt+1.
- Write (we!=0), in range:
  - Lanes with we[i]=1 take sram_wdata lane i; other lanes keep their value.
  - Read-first: sram_rdata <= old mem[idx].
  - wr_cnt+1.
- Out of range: no array write; sram_rdata <= 32'h0; oob_cnt+1.
- No request (sram_en=0): sram_rdata holds its previous value; counters hold.
- Read-after-write to the same word on consecutive cycles returns the merged new value (array write at edge N, read at edge N+1).
- Back-to-back requests every cycle are supported; no stall or backpressure exists.
- Counters saturate at all-ones; no wrap.
- Exactly one counter increments per accepted request.

Decomposition:
- Shared package:
  - FSM state encoding (INIT, READY).
  - DATA_W=32, WE_W=4 constants.
  - Function for byte-lane merge of (old, wdata, we).
- Sub-module sram_be_array: 2**ADDR_W x 32 synchronous array, one port, per-lane write enable, read-first registered output.
  - The responder wraps it with the INIT FSM, window decode, rdata zeroing mux and counters.
- Counters: one generic saturating counter instantiated three times.

Test Plan:
- Reset release, ADDR_W=4 -> init_done rises exactly 16 cycles after reset deasserts. A read of BASE_ADDR+0x3c issued during INIT -> rdata 0, rd_cnt 0. A read after init_done -> rdata 0, rd_cnt 1.
- Write 32'hdeadbeef, we=4'hf, addr BASE+8; next cycle read BASE+8 -> rdata 32'hdeadbeef one cycle after the read; wr_cnt=1, rd_cnt=1.
- Word initially 32'hdeadbeef; write 32'h11223344, we=4'b0101 -> subsequent read returns 32'hde22be44. The write cycle's rdata returns old 32'hdeadbeef.
- Access at BASE_ADDR-4 and at BASE_ADDR+4*2**ADDR_W with we=4'hf -> rdata 0, oob_cnt=2, array unchanged (verified by reading idx 0 and idx 15).
- Back-to-back writes to idx 0..15 then reads of idx 0..15, en held high throughout -> each rdata matches the written data one cycle after its read; wr_cnt=16, rd_cnt=16.
- Assert reset while mid-traffic in READY -> rdata, counters and init_done drop to 0 immediately (async). The subsequent INIT re-zeroes the array: a read of a previously written word returns 0.
